// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, command record and response record.
package apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master; master = requester view.
interface apb_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();

   // Handshakes: a beat transfers on a rising pclk where valid & ready are both 1;
   // once raised, valid and its payload stay stable until that transfer edge.
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic              pslverr;
   logic [DATA_W-1:0] prdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  pready, pslverr, prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output pready, pslverr, prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command -> one SETUP+ACCESS transfer -> one response.
// Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         pclk,
   input  logic         preset_n,
   apb_master_if.master bus,
   output apb_state_e   dbg_state
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             to_hit;

   // The current ACCESS cycle is the last allowed one without pready.
   assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d   = SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = bus.cmd_write;
               paddr_d   = bus.cmd_addr;
               pwdata_d  = bus.cmd_wdata;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
         end
         ACCESS: begin
            // pready takes priority over a timeout that expires on the same cycle.
            if (bus.pready) begin
               state_d     = RESP;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
               rsp_err_d   = bus.pslverr;
`ifdef APB_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (to_hit) begin
               state_d       = RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
`endif
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         to_cnt_q      <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
         to_cnt_q      <= to_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   // Gated by reset so every output reads 0 while preset_n is low.
   assign bus.cmd_ready = preset_n && (state_q == IDLE);
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign bus.rsp_timeout = 1'b0;
`endif
   assign dbg_state = state_q;

endmodule
